// File: rtl/adc_trig_capture.sv
`default_nettype none
// ============================================================================
// Module   : adc_trig_capture
// Brief    : Multi-channel ADC capture buffer with level trigger, pre/post
//            trigger window, decimation and sequential readout.
// Revision : 1.0 - initial release
// ============================================================================
module adc_trig_capture #(
    parameter  int DATA_W = 12,
    parameter  int CH_NUM = 2,
    parameter  int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int SEL_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
    localparam int WORD_W = CH_NUM * DATA_W
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [WORD_W-1:0] adc_data,
    input  logic              adc_vld,
    input  logic              arm,
    input  logic [SEL_W-1:0]  trig_src,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_falling,
    input  logic              force_trig,
    input  logic [ADDR_W-1:0] pre_len,
    input  logic [7:0]        decim,
    input  logic              rd_en,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_vld,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_pre   = 3'd1;
    localparam logic [2:0] c_armed = 3'd2;
    localparam logic [2:0] c_post  = 3'd3;
    localparam logic [2:0] c_done  = 3'd4;

    localparam logic [ADDR_W:0]   c_depth    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_cnt_one  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;

    logic [SEL_W-1:0]  r_src;
    logic [DATA_W-1:0] r_level;
    logic              r_falling;
    logic [ADDR_W-1:0] r_pre_len;
    logic [7:0]        r_decim;

    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [7:0]        r_dec_cnt;
    logic [ADDR_W:0]   r_cnt;
    logic [DATA_W-1:0] r_prev;
    logic              r_prev_vld;
    logic              r_force_pend;

    logic [WORD_W-1:0] r_mem [DEPTH];

    logic [DATA_W-1:0] w_cur;
    logic              w_active;
    logic              w_accept;
    logic              w_edge;
    logic              w_trig;
    logic              w_read;
    logic [ADDR_W:0]   w_post_len;
    logic [ADDR_W:0]   w_cnt_inc;

    // Trigger channel select; out-of-range indices fall back to channel 0
    always_comb begin
        w_cur = adc_data[DATA_W-1:0];
        for (int k = 0; k < CH_NUM; k++) begin
            if (r_src == SEL_W'(k)) begin
                w_cur = adc_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_active   = (r_state == c_pre) || (r_state == c_armed) || (r_state == c_post);
    assign w_accept   = w_active && adc_vld && !arm && (r_dec_cnt == 8'd0);
    assign w_edge     = r_prev_vld &&
                        (r_falling ? ((r_prev >= r_level) && (w_cur <  r_level))
                                   : ((r_prev <  r_level) && (w_cur >= r_level)));
    assign w_trig     = w_accept && (r_state == c_armed) && (r_force_pend || w_edge);
    assign w_read     = (r_state == c_done) && rd_en && !arm;
    assign w_post_len = c_depth - {1'b0, r_pre_len};
    assign w_cnt_inc  = r_cnt + c_cnt_one;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (arm) begin
            w_state_nxt = (pre_len == '0) ? c_armed : c_pre;
        end else begin
            case (r_state)
                c_pre:   if (w_accept && (w_cnt_inc == {1'b0, r_pre_len})) w_state_nxt = c_armed;
                c_armed: if (w_trig) w_state_nxt = (w_post_len == c_cnt_one) ? c_done : c_post;
                c_post:  if (w_accept && (w_cnt_inc == w_post_len)) w_state_nxt = c_done;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        busy = (r_state == c_pre) || (r_state == c_armed) || (r_state == c_post);
        done = (r_state == c_done);
    end

    always_ff @(posedge clk_in) begin
        if (w_accept) begin
            r_mem[r_wptr] <= adc_data;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_src        <= '0;
            r_level      <= '0;
            r_falling    <= 1'b0;
            r_pre_len    <= '0;
            r_decim      <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_dec_cnt    <= '0;
            r_cnt        <= '0;
            r_prev       <= '0;
            r_prev_vld   <= 1'b0;
            r_force_pend <= 1'b0;
            rd_data      <= '0;
            rd_vld       <= 1'b0;
        end else if (arm) begin
            r_src        <= trig_src;
            r_level      <= trig_level;
            r_falling    <= trig_falling;
            r_pre_len    <= pre_len;
            r_decim      <= decim;
            r_wptr       <= '0;
            r_dec_cnt    <= '0;
            r_cnt        <= '0;
            r_prev_vld   <= 1'b0;
            r_force_pend <= 1'b0;
            rd_vld       <= 1'b0;
        end else begin
            rd_vld <= w_read;
            if (w_active && adc_vld) begin
                r_dec_cnt <= (r_dec_cnt == r_decim) ? 8'd0 : r_dec_cnt + 8'd1;
            end
            if (w_accept) begin
                r_wptr     <= r_wptr + c_addr_one;
                r_cnt      <= w_trig ? c_cnt_one : w_cnt_inc;
                r_prev     <= w_cur;
                r_prev_vld <= 1'b1;
            end
            // Forced trigger fires on the first accepted sample after the pulse
            if (w_trig) begin
                r_force_pend <= 1'b0;
                r_rptr       <= r_wptr - r_pre_len;
            end else if ((r_state == c_armed) && force_trig) begin
                r_force_pend <= 1'b1;
            end
            if (w_read) begin
                rd_data <= r_mem[r_rptr];
                r_rptr  <= r_rptr + c_addr_one;
            end
        end
    end

endmodule
`default_nettype wire
